tx_serializer: RTL
==================

TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter GUARD, default 2, meaning idle-high cycles after the last instruction bit before the next start bit (legal range 2..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning frame buffer depth when TX_FIFO_EN is defined (power of two, 2..16).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk2, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port send_valid, input, 1 bit: a frame is offered on data_in/instr_in.
REQ-007 SHALL have port send_ready, output, 1 bit: a frame can be accepted this cycle.
REQ-008 SHALL have port data_in, input, 4 bits: data nibble.
REQ-009 SHALL have port instr_in, input, 4 bits: instruction nibble (1 = clean, 2 = store, 4 = show).
REQ-010 SHALL have port transmission, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE or a frame is buffered.
REQ-012 SHALL have port drop, output, 1 bit: one-cycle pulse when an offered frame is rejected.

Function
REQ-013 SHALL accept a frame on a rising edge where send_valid && send_ready.
REQ-014 SHALL reject an offered frame whose instr_in is not 1, 2 or 4: no storage, no transmission; drop high for the following cycle; send_ready is unaffected.
REQ-015 SHALL run FSM states IDLE -> START -> DATA (4 cycles) -> INSTR (4 cycles) -> GUARD (GUARD cycles) -> IDLE, or directly -> START when another frame is buffered.
REQ-016 SHALL drive transmission from a register: START = 0; DATA = data bits 0..3, LSB first; INSTR = instr bits 0..3, LSB first; IDLE and GUARD = 1.
REQ-017 SHALL keep each bit exactly one clk2 cycle; a full frame is 1 + 8 + GUARD cycles.
REQ-018 SHALL, for a frame accepted at edge N with the FSM in IDLE, drive the start bit from edge N+1 (without FIFO) or N+2 (with FIFO), with no bubble between bits.
REQ-019 SHALL latch the frame at acceptance; later changes on data_in/instr_in SHALL NOT affect a frame in flight.
REQ-020 SHALL, when GUARD ends with a frame buffered, enter START on the next edge; back-to-back frames are separated by exactly GUARD high cycles.
REQ-021 SHALL never emit a partial frame except when reset occurs mid-frame.

Reset
REQ-022 SHALL, on rst asserted, immediately force FSM = IDLE, transmission = 1, busy = 0, drop = 0, and send_ready = 0 while rst is high.
REQ-023 SHALL discard the in-flight frame and all buffered frames on reset; send_ready = 1 on the first edge after rst deasserts.

Configuration
REQ-024 SHALL use macro TX_SERIALIZER_FIFO_EN: when defined, a FIFO_DEPTH-entry frame FIFO; send_ready = !full, and a push and a pop in the same cycle when full SHALL both occur.
REQ-025 SHALL, without TX_SERIALIZER_FIFO_EN, use a single holding register: send_ready = 1 only in IDLE with nothing held; FIFO_DEPTH is ignored.

Structure
REQ-026 SHALL take from shared package tx_pkg: instruction codes INSTR_CLEAN = 1, INSTR_STORE = 2, INSTR_SHOW = 4, the FSM state enum, and constants DATA_BITS = 4 and INSTR_BITS = 4.
REQ-027 SHALL place the frame buffer in sub-module tx_fifo (8-bit entries, full/empty flags, wrap-around pointers) when FIFO is enabled.

Verification
REQ-028 SHALL cover: reset then offer data 0xA, instr 2 -> line 1,0,0,1,0,1,0,1,0,0 then GUARD high cycles; busy falls after GUARD.
REQ-029 SHALL cover: offer instr 3 -> drop pulses one cycle, line stays 1, busy stays 0.
REQ-030 SHALL cover: with FIFO, 5 frames offered back-to-back -> send_ready low after 4 buffered frames; all 5 sent in order with exactly 2 high cycles between frames.
REQ-031 SHALL cover: rst pulsed during the DATA of frame 0x3/4 -> line 1 immediately, buffer empty, no further bits.
REQ-032 SHALL cover: a reference rx model on the same clk2 receives frames (7,2) then (7,4) -> store then show performed, display value 7.
REQ-033 SHALL cover: data_in/instr_in changed every cycle during transmission -> serial bits match the accepted frame.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the serial frame transmitter: field widths, instruction codes,
// transmit FSM states and the instruction legality check.
package tx_pkg;

  localparam int DATA_BITS  = 4;
  localparam int INSTR_BITS = 4;
  localparam int FRAME_BITS = DATA_BITS + INSTR_BITS;

  localparam logic [INSTR_BITS-1:0] INSTR_CLEAN = 4'd1;
  localparam logic [INSTR_BITS-1:0] INSTR_STORE = 4'd2;
  localparam logic [INSTR_BITS-1:0] INSTR_SHOW  = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_INSTR,
    ST_GUARD
  } tx_state_t;

  function automatic logic instr_ok(input logic [INSTR_BITS-1:0] code);
    return (code == INSTR_CLEAN) || (code == INSTR_STORE) || (code == INSTR_SHOW);
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Frame buffer for tx_serializer: DEPTH entries, wrap-around pointers with an extra
// lap bit for full/empty, and a simultaneous push+pop allowed when full.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries hold live frames.
  always_ff @(posedge clk2) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/tx_serializer.sv
// Serial frame transmitter: start bit, data nibble, instruction nibble (LSB first), then GUARD
// idle-high cycles. Define TX_SERIALIZER_FIFO_EN to put a FIFO_DEPTH-entry frame FIFO in front.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int GUARD      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk2,
  input  logic                  rst,
  input  logic                  send_valid,
  output logic                  send_ready,
  input  logic [DATA_BITS-1:0]  data_in,
  input  logic [INSTR_BITS-1:0] instr_in,
  output logic                  transmission,
  output logic                  busy,
  output logic                  drop
);

  tx_state_t             state;
  logic [3:0]            cnt;
  logic [DATA_BITS-1:0]  data_q;
  logic [INSTR_BITS-1:0] instr_q;
  logic                  ready_en;
  logic                  tail_q;
  logic                  offered_ok;
  logic                  accept;
  logic                  guard_last;
  logic                  load;
  logic [FRAME_BITS-1:0] load_frame;

  assign offered_ok = instr_ok(instr_in);
  assign accept     = send_valid && send_ready && offered_ok;
  assign guard_last = (state == ST_GUARD) && (cnt == 4'(GUARD - 1));

`ifdef TX_SERIALIZER_FIFO_EN
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FRAME_BITS-1:0] fifo_q;

  // A pop frees a slot on the same edge, so a full FIFO still takes a frame while the FSM pulls one.
  assign load       = !fifo_empty && ((state == ST_IDLE) || guard_last);
  assign load_frame = fifo_q;
  assign send_ready = ready_en && (!fifo_full || load);
  assign busy       = (state != ST_IDLE) || tail_q || !fifo_empty;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_BITS)
  ) u_fifo (
    .clk2    (clk2),
    .rst     (rst),
    .push    (accept),
    .pop     (load),
    .wr_data ({instr_in, data_in}),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
`else
  logic unused_depth;

  assign unused_depth = (FIFO_DEPTH != 0);
  assign load         = accept;
  assign load_frame   = {instr_in, data_in};
  assign send_ready   = ready_en && (state == ST_IDLE);
  assign busy         = (state != ST_IDLE) || tail_q;
`endif

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      data_q       <= '0;
      instr_q      <= '0;
      transmission <= 1'b1;
      drop         <= 1'b0;
      tail_q       <= 1'b0;
      ready_en     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      drop     <= send_valid && send_ready && !offered_ok;
      tail_q   <= guard_last && !load;

      // The line trails the state by one cycle, so each bit is held for exactly one full cycle.
      unique case (state)
        ST_START: transmission <= 1'b0;
        ST_DATA:  transmission <= data_q[cnt[1:0]];
        ST_INSTR: transmission <= instr_q[cnt[1:0]];
        default:  transmission <= 1'b1;
      endcase

      unique case (state)
        ST_IDLE: begin
          if (load) begin
            {instr_q, data_q} <= load_frame;
            state             <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_DATA;
          cnt   <= '0;
        end
        ST_DATA: begin
          if (cnt == 4'(DATA_BITS - 1)) begin
            state <= ST_INSTR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_INSTR: begin
          if (cnt == 4'(INSTR_BITS - 1)) begin
            state <= ST_GUARD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_GUARD: begin
          if (guard_last) begin
            if (load) begin
              {instr_q, data_q} <= load_frame;
              state             <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
